inst_fetch_axi: RTL and testbench

- Instruction-fetch stage of the core.
- Accepts a PC from the PC stage and issues a single-beat AXI4 read to the instruction-memory slave.
- Returns the instruction word to decode as inst/inst_valid, and holds it while the core is stalled.
- Drives inst_mem_wait so the PC stage and the core stall logic know a fetch is outstanding.

---
 rtl/inst_fetch_pkg.sv | 15 +
 rtl/inst_fetch_axi_if.sv | 27 ++
 rtl/fetch_hit_buf.sv | 37 +++
 rtl/inst_fetch_axi.sv | 137 +++++++++++++
 tb/tb_inst_fetch_axi.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared constants for the instruction-fetch stage: FSM encoding and fixed AXI4 read fields.
// No logic; latency and backpressure are defined by the modules that import it.
package inst_fetch_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [2:0] ARSIZE_WORD  = 3'b010;
    localparam logic [1:0] ARBURST_INCR = 2'b01;
    localparam logic [7:0] ARLEN_SINGLE = 8'd0;

endpackage

// File: rtl/inst_fetch_axi_if.sv
// AXI4 read-channel bundle (AR + R) between the fetch stage and instruction memory.
// master = fetch stage, slave = memory; flow control is plain AXI valid/ready.
interface inst_fetch_axi_if #(
    parameter int C_AXI_DATA_WIDTH = 32
);
    logic [31:0]                 M_AXI_ARADDR;
    logic [7:0]                  M_AXI_ARLEN;
    logic [2:0]                  M_AXI_ARSIZE;
    logic [1:0]                  M_AXI_ARBURST;
    logic                        M_AXI_ARVALID;
    logic                        M_AXI_ARREADY;
    logic [C_AXI_DATA_WIDTH-1:0] M_AXI_RDATA;
    logic [1:0]                  M_AXI_RRESP;
    logic                        M_AXI_RLAST;
    logic                        M_AXI_RVALID;
    logic                        M_AXI_RREADY;

    modport master (
        output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID, M_AXI_RREADY,
        input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
    );

    modport slave (
        input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID, M_AXI_RREADY,
        output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
    );
endinterface

// File: rtl/fetch_hit_buf.sv
// One-entry buffer of the last OKAY fetch (tag, data, valid); combinational hit lookup.
// Lookup latency 0, load visible next cycle; no backpressure, loads are always accepted.
module fetch_hit_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data,
    input  logic              load_en,
    input  logic              load_okay,
    input  logic [31:0]       load_addr,
    input  logic [DATA_W-1:0] load_data
);
    logic [31:0]       tag_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_en) begin
            // An error response may alias the cached address, so drop the entry entirely
            valid_q <= load_okay;
            if (load_okay) begin
                tag_q  <= load_addr;
                data_q <= load_data;
            end
        end
    end

    assign hit      = valid_q && (tag_q == lookup_addr);
    assign hit_data = data_q;
endmodule

// File: rtl/inst_fetch_axi.sv
// Instruction fetch: one single-beat AXI4 read per accepted PC, word held for decode until STALL drops.
// Latency 3 cycles PC->INST_VALID with a zero-wait slave (1 on a hit when INST_FETCH_HIT_BUF_EN is defined).
// Backpressure: PC_READY only in IDLE; STALL holds INST in HOLD; slave wait states add cycles 1:1.
module inst_fetch_axi
    import inst_fetch_pkg::*;
#(
    parameter int          C_AXI_DATA_WIDTH = 32,
    parameter int          C_OFFSET_WIDTH   = 28,
    parameter logic [31:0] C_BASE_ADDR      = 32'h0000_0000
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [31:0]                 PC,
    input  logic                        PC_VALID,
    output logic                        PC_READY,
    input  logic                        STALL,
    output logic [C_AXI_DATA_WIDTH-1:0] INST,
    output logic                        INST_VALID,
    output logic                        INST_MEM_WAIT,
    output logic                        FETCH_ERR,
    inst_fetch_axi_if.master            m_axi
);
    logic [1:0]                  state_q;
    logic [C_AXI_DATA_WIDTH-1:0] inst_q;
    logic                        inst_vld_q;
    logic                        err_q;
    logic                        arvalid_q;
    logic                        rready_q;
    logic [31:0]                 araddr_q;
    logic [31:0]                 araddr_nxt;
    logic                        pc_misaligned;
    logic                        r_hs;
    logic                        r_okay;
    logic                        hit;
    logic [C_AXI_DATA_WIDTH-1:0] hit_data;

    // Offset field is always word-aligned; base bits sit above it
    assign araddr_nxt    = C_BASE_ADDR | {{(32-C_OFFSET_WIDTH){1'b0}}, PC[C_OFFSET_WIDTH-1:2], 2'b00};
    assign pc_misaligned = (PC[1:0] != 2'b00);
    assign r_hs          = m_axi.M_AXI_RVALID && rready_q;
    assign r_okay        = (m_axi.M_AXI_RRESP == RRESP_OKAY);

`ifdef INST_FETCH_HIT_BUF_EN
    fetch_hit_buf #(
        .DATA_W (C_AXI_DATA_WIDTH)
    ) u_hit_buf (
        .clk         (CLK),
        .rst         (RST),
        .lookup_addr (araddr_nxt),
        .hit         (hit),
        .hit_data    (hit_data),
        .load_en     (r_hs),
        .load_okay   (r_okay),
        .load_addr   (araddr_q),
        .load_data   (m_axi.M_AXI_RDATA)
    );
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            inst_q     <= '0;
            inst_vld_q <= 1'b0;
            err_q      <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            araddr_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (PC_VALID) begin
                        if (pc_misaligned) begin
                            inst_q     <= '0;
                            err_q      <= 1'b1;
                            inst_vld_q <= 1'b1;
                            state_q    <= ST_HOLD;
                        end else if (hit) begin
                            inst_q     <= hit_data;
                            err_q      <= 1'b0;
                            inst_vld_q <= 1'b1;
                            state_q    <= ST_HOLD;
                        end else begin
                            araddr_q  <= araddr_nxt;
                            arvalid_q <= 1'b1;
                            state_q   <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (m_axi.M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // STALL is deliberately ignored: the beat must be drained
                    if (r_hs) begin
                        inst_q     <= m_axi.M_AXI_RDATA;
                        err_q      <= !r_okay;
                        inst_vld_q <= 1'b1;
                        rready_q   <= 1'b0;
                        state_q    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!STALL) begin
                        inst_vld_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign PC_READY      = (state_q == ST_IDLE);
    assign INST_MEM_WAIT = (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign INST          = inst_q;
    assign INST_VALID    = inst_vld_q;
    assign FETCH_ERR     = err_q;

    assign m_axi.M_AXI_ARADDR  = araddr_q;
    assign m_axi.M_AXI_ARLEN   = ARLEN_SINGLE;
    assign m_axi.M_AXI_ARSIZE  = ARSIZE_WORD;
    assign m_axi.M_AXI_ARBURST = ARBURST_INCR;
    assign m_axi.M_AXI_ARVALID = arvalid_q;
    assign m_axi.M_AXI_RREADY  = rready_q;

    // Upper PC bits above the offset field and RLAST carry no information here
    wire unused_ok = &{1'b0, PC[31:C_OFFSET_WIDTH], m_axi.M_AXI_RLAST};
endmodule

// File: tb/tb_inst_fetch_axi.sv
// Directed bench for inst_fetch_axi with a behavioural single-beat AXI slave (word i holds i).
// Cycle 0 is the cycle PC_VALID is presented; outputs are sampled 1 time unit after each rising edge.
module tb_inst_fetch_axi;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic        stall;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_mem_wait;
    logic        fetch_err;

    inst_fetch_axi_if #(.C_AXI_DATA_WIDTH(32)) axi ();

    inst_fetch_axi dut (
        .CLK           (clk),
        .RST           (rst),
        .PC            (pc),
        .PC_VALID      (pc_valid),
        .PC_READY      (pc_ready),
        .STALL         (stall),
        .INST          (inst),
        .INST_VALID    (inst_valid),
        .INST_MEM_WAIT (inst_mem_wait),
        .FETCH_ERR     (fetch_err),
        .m_axi         (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          ar_delay = 0;
    int          r_delay  = 0;
    int          ar_cnt   = 0;
    int          r_cnt    = 0;
    int          arv_cycles;
    logic [1:0]  rresp_cfg = 2'b00;
    logic [31:0] ar_addr_lat = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle, then drive the slave's response for the new cycle
    task automatic tick();
        if (axi.M_AXI_ARVALID && axi.M_AXI_ARREADY) ar_addr_lat = axi.M_AXI_ARADDR;
        @(posedge clk);
        #1;
        cyc++;
        if (axi.M_AXI_ARVALID) begin
            axi.M_AXI_ARREADY = (ar_cnt >= ar_delay);
            ar_cnt++;
        end else begin
            axi.M_AXI_ARREADY = 1'b0;
            ar_cnt = 0;
        end
        if (axi.M_AXI_RREADY) begin
            axi.M_AXI_RVALID = (r_cnt >= r_delay);
            axi.M_AXI_RDATA  = ar_addr_lat >> 2;
            axi.M_AXI_RRESP  = rresp_cfg;
            axi.M_AXI_RLAST  = 1'b1;
            r_cnt++;
        end else begin
            axi.M_AXI_RVALID = 1'b0;
            axi.M_AXI_RDATA  = '0;
            axi.M_AXI_RRESP  = 2'b00;
            axi.M_AXI_RLAST  = 1'b0;
            r_cnt = 0;
        end
    endtask

    task automatic start_fetch(input logic [31:0] addr);
        pc       = addr;
        pc_valid = 1'b1;
        cyc      = 0;
        tick();
        pc_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; pc = '0; pc_valid = 1'b0; stall = 1'b0;
        axi.M_AXI_ARREADY = 1'b0; axi.M_AXI_RVALID = 1'b0;
        axi.M_AXI_RDATA = '0; axi.M_AXI_RRESP = 2'b00; axi.M_AXI_RLAST = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_pc_ready", pc_ready, 1);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst", inst, 0);
        check("rst_fetch_err", fetch_err, 0);
        check("rst_arvalid", axi.M_AXI_ARVALID, 0);
        check("rst_rready", axi.M_AXI_RREADY, 0);
        check("rst_araddr", axi.M_AXI_ARADDR, 0);
        check("rst_wait", inst_mem_wait, 0);

        // 1: zero-wait fetch of PC=0x8
        start_fetch(32'h8);
        check("t1_c1_arvalid", axi.M_AXI_ARVALID, 1);
        check("t1_c1_araddr", axi.M_AXI_ARADDR, 32'h8);
        check("t1_c1_wait", inst_mem_wait, 1);
        check("t1_c1_pc_ready", pc_ready, 0);
        check("t1_arlen", axi.M_AXI_ARLEN, 0);
        check("t1_arsize", axi.M_AXI_ARSIZE, 3'b010);
        check("t1_arburst", axi.M_AXI_ARBURST, 2'b01);
        tick();
        check("t1_c2_rready", axi.M_AXI_RREADY, 1);
        check("t1_c2_arvalid", axi.M_AXI_ARVALID, 0);
        check("t1_c2_wait", inst_mem_wait, 1);
        tick();
        check("t1_c3_inst_valid", inst_valid, 1);
        check("t1_c3_inst", inst, 32'h2);
        check("t1_c3_err", fetch_err, 0);
        check("t1_c3_wait", inst_mem_wait, 0);
        tick();
        check("t1_c4_inst_valid", inst_valid, 0);
        check("t1_c4_pc_ready", pc_ready, 1);

        // 2: ARREADY 3 cycles late, RVALID 2 cycles late
        ar_delay = 3; r_delay = 2;
        arv_cycles = 0;
        start_fetch(32'hC);
        while (cyc < 8) begin
            check("t2_pc_ready", pc_ready, 0);
            check("t2_inst_valid", inst_valid, 0);
            if (axi.M_AXI_ARVALID) begin
                arv_cycles++;
                check("t2_araddr", axi.M_AXI_ARADDR, 32'hC);
            end
            tick();
        end
        check("t2_arvalid_cycles", arv_cycles, 4);
        check("t2_c8_inst_valid", inst_valid, 1);
        check("t2_c8_inst", inst, 32'h3);
        ar_delay = 0; r_delay = 0;
        tick();

        // 3: STALL high for cycles 2..9, dropped at cycle 10
        start_fetch(32'h10);
        while (cyc < 11) begin
            stall = (cyc >= 2 && cyc <= 9);
            if (cyc >= 3) begin
                check("t3_hold_valid", inst_valid, 1);
                check("t3_hold_inst", inst, 32'h4);
            end
            tick();
        end
        stall = 1'b0;
        check("t3_c11_inst_valid", inst_valid, 0);
        check("t3_c11_pc_ready", pc_ready, 1);

        // 4: misaligned PC, then error response
        start_fetch(32'h6);
        check("t4_mis_arvalid", axi.M_AXI_ARVALID, 0);
        check("t4_mis_inst_valid", inst_valid, 1);
        check("t4_mis_err", fetch_err, 1);
        check("t4_mis_inst", inst, 0);
        tick();
        check("t4_mis_release", inst_valid, 0);
        rresp_cfg = 2'b10;
        start_fetch(32'h0);
        tick();
        tick();
        check("t4_slverr_valid", inst_valid, 1);
        check("t4_slverr_err", fetch_err, 1);
        rresp_cfg = 2'b00;
        tick();

        // 5: reset while in DATA
        r_delay = 5;
        start_fetch(32'h14);
        tick();
        check("t5_c2_rready", axi.M_AXI_RREADY, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_arvalid", axi.M_AXI_ARVALID, 0);
        check("t5_rst_rready", axi.M_AXI_RREADY, 0);
        check("t5_rst_inst_valid", inst_valid, 0);
        check("t5_rst_pc_ready", pc_ready, 1);
        r_delay = 0;
        start_fetch(32'h4);
        tick();
        tick();
        check("t5_refetch_valid", inst_valid, 1);
        check("t5_refetch_inst", inst, 32'h1);
        tick();

        // 6: same PC fetched back to back
        start_fetch(32'h20);
        tick();
        tick();
        check("t6_first_inst", inst, 32'h8);
        tick();
        start_fetch(32'h20);
`ifdef INST_FETCH_HIT_BUF_EN
        check("t6_hit_arvalid", axi.M_AXI_ARVALID, 0);
        check("t6_hit_valid", inst_valid, 1);
        check("t6_hit_inst", inst, 32'h8);
        check("t6_hit_err", fetch_err, 0);
`else
        check("t6_miss_arvalid", axi.M_AXI_ARVALID, 1);
        check("t6_miss_araddr", axi.M_AXI_ARADDR, 32'h20);
        tick();
        tick();
        check("t6_miss_valid", inst_valid, 1);
        check("t6_miss_inst", inst, 32'h8);
`endif
        tick();
        check("t6_release", inst_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
